linefill_arbiter: RTL and testbench

- Shares one linefill buffer, and its AXI read path, between the instruction-cache and data-cache miss handlers.
- Grants one miss at a time and drives the buffer's Enable and Address.
- Forwards the critical-word strobe to the owner and returns the completed 256-bit line with a one-cycle done pulse.
- Watchdog aborts a fill that never completes.

---
 rtl/linefill_arbiter_if.sv | 38 +++
 rtl/linefill_arbiter.sv | 121 ++++++++++++
 tb/tb_linefill_arbiter.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/linefill_arbiter_if.sv
// rtl/linefill_arbiter_if.sv - cache miss, line return and linefill buffer signals of linefill_arbiter
interface linefill_arbiter_if #(
    parameter int LINE_WIDTH = 256
);
    logic                  IReq;
    logic [31:0]           IAddr;
    logic                  IDone;
    logic                  ICritValid;
    logic                  DReq;
    logic [31:0]           DAddr;
    logic                  DDone;
    logic                  DCritValid;
    logic [LINE_WIDTH-1:0] LineOut;
    logic [31:0]           CritWord;
    logic                  Error;
    logic                  Busy;
    logic                  Owner;
    logic                  LfbEnable;
    logic [31:0]           LfbAddress;
    logic                  LfbFirstData;
    logic [31:0]           LfbCritWord;
    logic                  LfbLineDone;
    logic [LINE_WIDTH-1:0] LfbLine;

    modport master (
        input  IReq, IAddr, DReq, DAddr,
        input  LfbFirstData, LfbCritWord, LfbLineDone, LfbLine,
        output IDone, ICritValid, DDone, DCritValid, LineOut, CritWord,
        output Error, Busy, Owner, LfbEnable, LfbAddress
    );

    modport slave (
        output IReq, IAddr, DReq, DAddr,
        output LfbFirstData, LfbCritWord, LfbLineDone, LfbLine,
        input  IDone, ICritValid, DDone, DCritValid, LineOut, CritWord,
        input  Error, Busy, Owner, LfbEnable, LfbAddress
    );
endinterface

// File: rtl/linefill_arbiter.sv
// rtl/linefill_arbiter.sv - shares one linefill buffer between I- and D-cache misses (LINEFILL_ARBITER_ROUND_ROBIN_EN)
module linefill_arbiter #(
    parameter int LINE_WIDTH = 256,
    parameter int TIMEOUT    = 64,
    parameter int CNT_W      = 8
) (
    input logic                Clk,
    input logic                Rst,
    linefill_arbiter_if.master bus
);
    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic                  owner_q;
    logic                  enable_q;
    logic                  busy_q;
    logic                  idone_q;
    logic                  ddone_q;
    logic                  error_q;
    logic [31:0]           addr_q;
    logic [LINE_WIDTH-1:0] line_q;
    logic                  grant_d;
    logic                  timeout_hit;
    logic                  icrit;
    logic                  dcrit;

`ifdef LINEFILL_ARBITER_ROUND_ROBIN_EN
    // Resets to D so that the first tie after reset goes to the I-cache.
    logic last_q;

    always_comb begin
        grant_d = bus.DReq;
        if (bus.IReq && bus.DReq) begin
            grant_d = ~last_q;
        end
    end
`else
    always_comb begin
        grant_d = bus.DReq;
    end
`endif

    assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));

    assign icrit = (state == FILL) && bus.LfbFirstData && !owner_q;
    assign dcrit = (state == FILL) && bus.LfbFirstData && owner_q;

    assign bus.ICritValid = icrit;
    assign bus.DCritValid = dcrit;
    assign bus.CritWord   = (icrit || dcrit) ? bus.LfbCritWord : 32'd0;
    assign bus.IDone      = idone_q;
    assign bus.DDone      = ddone_q;
    assign bus.Error      = error_q;
    assign bus.Busy       = busy_q;
    assign bus.Owner      = owner_q;
    assign bus.LfbEnable  = enable_q;
    assign bus.LfbAddress = addr_q;
    assign bus.LineOut    = line_q;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state    <= IDLE;
            cnt      <= '0;
            owner_q  <= 1'b0;
            enable_q <= 1'b0;
            busy_q   <= 1'b0;
            idone_q  <= 1'b0;
            ddone_q  <= 1'b0;
            error_q  <= 1'b0;
            addr_q   <= 32'd0;
            line_q   <= '0;
`ifdef LINEFILL_ARBITER_ROUND_ROBIN_EN
            last_q   <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (bus.IReq || bus.DReq) begin
                        owner_q  <= grant_d;
                        addr_q   <= grant_d ? bus.DAddr : bus.IAddr;
                        enable_q <= 1'b1;
                        busy_q   <= 1'b1;
                        state    <= FILL;
`ifdef LINEFILL_ARBITER_ROUND_ROBIN_EN
                        last_q   <= grant_d;
`endif
                    end
                end
                FILL: begin
                    // Line completion takes precedence over a coincident timeout.
                    if (bus.LfbLineDone || timeout_hit) begin
                        if (bus.LfbLineDone) begin
                            line_q <= bus.LfbLine;
                        end
                        error_q  <= !bus.LfbLineDone;
                        idone_q  <= !owner_q;
                        ddone_q  <= owner_q;
                        enable_q <= 1'b0;
                        cnt      <= '0;
                        state    <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    idone_q <= 1'b0;
                    ddone_q <= 1'b0;
                    error_q <= 1'b0;
                    busy_q  <= 1'b0;
                    cnt     <= '0;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_linefill_arbiter.sv
// tb/tb_linefill_arbiter.sv - randomized self-checking bench for linefill_arbiter
module tb_linefill_arbiter;
    localparam int LW = 256;
    localparam int TO = 12;

    logic Clk = 1'b0;
    logic Rst;
    always #5 Clk = ~Clk;

    linefill_arbiter_if #(.LINE_WIDTH(LW)) bus ();

    linefill_arbiter #(
        .LINE_WIDTH(LW),
        .TIMEOUT   (TO),
        .CNT_W     (8)
    ) dut (
        .Clk(Clk),
        .Rst(Rst),
        .bus(bus)
    );

    int            n_cmp = 0;
    int            n_bad = 0;
    bit            last_grant = 1'b1;
    logic [LW-1:0] exp_line = '0;

    task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] l;
        for (int i = 0; i < LW / 32; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    // Arbitration rule: single request wins outright; ties go D (fixed) or to the non-last owner (round robin).
    function automatic bit pick_d();
        if (bus.IReq && bus.DReq) begin
`ifdef LINEFILL_ARBITER_ROUND_ROBIN_EN
            return !last_grant;
`else
            return 1'b1;
`endif
        end
        return bus.DReq;
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_en"}, bus.LfbEnable, 0);
        check({tag, "_busy"}, bus.Busy, 0);
        check({tag, "_idone"}, bus.IDone, 0);
        check({tag, "_ddone"}, bus.DDone, 0);
        check({tag, "_err"}, bus.Error, 0);
    endtask

    // ld < 0 means the buffer never reports line done; rst_at >= 0 pulses Rst in that FILL cycle.
    task automatic run_fill(input int fd, input int ld, input bit drop, input int rst_at);
        bit            d;
        logic [31:0]   a;
        logic [31:0]   w;
        logic [LW-1:0] l;
        int            last_k;
        bit            tmo;
        d = pick_d();
        a = d ? bus.DAddr : bus.IAddr;
        last_grant = d;
        tmo = !(ld >= 0 && ld <= TO - 1);
        last_k = tmo ? TO - 1 : ld;
        @(negedge Clk);
        check("grant_en", bus.LfbEnable, 1);
        check("grant_addr", bus.LfbAddress, a);
        check("grant_owner", bus.Owner, d);
        check("grant_busy", bus.Busy, 1);
        for (int k = 0; k <= last_k; k++) begin
            if (k > 0) begin
                @(negedge Clk);
                check("fill_en", bus.LfbEnable, 1);
                check("fill_done", bus.IDone | bus.DDone, 0);
            end
            if (rst_at == k) begin
                Rst = 1'b1;
                bus.LfbFirstData = 1'b0;
                bus.LfbLineDone = 1'b0;
                bus.IReq = 1'b0;
                bus.DReq = 1'b0;
                @(negedge Clk);
                exp_line = '0;
                last_grant = 1'b1;
                check_idle("rst");
                check("rst_owner", bus.Owner, 0);
                check("rst_addr", bus.LfbAddress, 0);
                check("rst_line", bus.LineOut, exp_line);
                Rst = 1'b0;
                return;
            end
            w = $urandom;
            l = rand_line();
            bus.LfbFirstData = (k == fd);
            bus.LfbCritWord = w;
            bus.LfbLineDone = (k == ld);
            bus.LfbLine = l;
            if (drop && k == 1) begin
                if (d) bus.DReq = 1'b0;
                else bus.IReq = 1'b0;
            end
            #1;
            check("icrit", bus.ICritValid, (k == fd) && !d);
            check("dcrit", bus.DCritValid, (k == fd) && d);
            check("crit_word", bus.CritWord, (k == fd) ? w : 32'd0);
            if (k == ld) exp_line = l;
        end
        @(negedge Clk);
        bus.LfbFirstData = 1'b0;
        bus.LfbLineDone = 1'b0;
        check("done_i", bus.IDone, !d);
        check("done_d", bus.DDone, d);
        check("done_err", bus.Error, tmo);
        check("done_en", bus.LfbEnable, 0);
        check("done_busy", bus.Busy, 1);
        check("done_line", bus.LineOut, exp_line);
        if (d) bus.DReq = 1'b0;
        else bus.IReq = 1'b0;
        @(negedge Clk);
        check_idle("gap");
    endtask

    task automatic serve_all(input bit rnd);
        while (bus.IReq || bus.DReq) begin
            int ld;
            ld = $urandom_range(TO + 3, 0);
            if (ld > TO + 1) ld = -1;
            run_fill($urandom_range(TO, 0), ld, rnd && ($urandom_range(3, 0) == 0), -1);
        end
        @(negedge Clk);
        check("no_regrant", bus.LfbEnable, 0);
    endtask

    initial begin
        Rst = 1'b1;
        bus.IReq = 1'b0;
        bus.IAddr = '0;
        bus.DReq = 1'b0;
        bus.DAddr = '0;
        bus.LfbFirstData = 1'b0;
        bus.LfbCritWord = '0;
        bus.LfbLineDone = 1'b0;
        bus.LfbLine = '0;
        repeat (2) @(negedge Clk);
        check_idle("reset");
        check("reset_line", bus.LineOut, 0);
        check("reset_owner", bus.Owner, 0);
        check("reset_addr", bus.LfbAddress, 0);
        check("reset_crit", bus.CritWord, 0);
        Rst = 1'b0;
        @(negedge Clk);

        bus.IReq = 1'b1;
        bus.IAddr = 32'h0000_1014;
        run_fill(2, 7, 1'b0, -1);

        for (int r = 0; r < 2; r++) begin
            bus.IReq = 1'b1;
            bus.IAddr = 32'h100;
            bus.DReq = 1'b1;
            bus.DAddr = 32'h200;
            serve_all(1'b0);
        end

        bus.DReq = 1'b1;
        bus.DAddr = 32'hDEAD_0040;
        run_fill(1, -1, 1'b0, -1);

        bus.IReq = 1'b1;
        bus.IAddr = 32'h0000_2000;
        run_fill(TO - 1, TO - 1, 1'b0, -1);

        bus.IReq = 1'b1;
        bus.IAddr = 32'h0000_3000;
        run_fill(0, 9, 1'b0, 2);
        bus.IReq = 1'b1;
        bus.IAddr = 32'h0000_3040;
        run_fill(0, 3, 1'b0, -1);

        bus.DReq = 1'b1;
        bus.DAddr = 32'h0000_4080;
        run_fill(0, 5, 1'b1, -1);
        repeat (2) begin
            @(negedge Clk);
            check("drop_idle", bus.LfbEnable, 0);
        end

        for (int r = 0; r < 60; r++) begin
            int p;
            p = $urandom_range(3, 1);
            bus.IReq = p[0];
            bus.DReq = p[1];
            bus.IAddr = $urandom;
            bus.DAddr = $urandom;
            serve_all(1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
